// File: rtl/pp3_cfg_frame_loader.sv
// ============================================================================
//  Module   : pp3_cfg_frame_loader
//  Purpose  : Parses framed configuration records from a byte stream,
//             validates address and XOR checksum, and commits each word to
//             the addressed PP3 LOGIC cell configuration latch.
//             Frame: A5, addr, NBYTES data (LSB byte first), checksum.
//  Options  : PP3_CFG_READBACK_EN adds a shadow array and a readback frame
//             (5A, addr, checksum) that returns the last committed word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp3_cfg_frame_loader #(
  parameter int NUM_CELLS = 4,
  parameter int CFG_BITS  = 16,
  parameter int ADDR_W    = 2
) (
  input  logic                QCK,
  input  logic                QRT,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic                cfg_we,
  output logic [ADDR_W-1:0]   cfg_addr,
  output logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
`ifdef PP3_CFG_READBACK_EN
  ,
  output logic                rb_valid,
  output logic [CFG_BITS-1:0] rb_data,
  input  logic                rb_ready
`endif
);

  localparam int         NBYTES     = CFG_BITS / 8;
  localparam int         CNT_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [7:0] C_HDR_CFG  = 8'hA5;
  localparam logic [7:0] C_HDR_RB   = 8'h5A;
  localparam logic [1:0] C_ERR_CHK  = 2'b01;
  localparam logic [1:0] C_ERR_ADDR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_bad_addr;
  logic [CFG_BITS-1:0] r_data;
  logic [7:0]          r_chk;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_xfer;
  logic                w_bad_addr;
  logic                w_last_byte;
  logic                w_rb_hold;

  assign w_xfer      = s_valid & s_ready;
  // Range check on the full received byte so high address bits are not lost.
  assign w_bad_addr  = ({1'b0, s_data} >= 9'(NUM_CELLS));
  assign w_last_byte = (r_cnt == CNT_W'(NBYTES - 1));

`ifdef PP3_CFG_READBACK_EN
  logic                r_rb;
  logic [CFG_BITS-1:0] r_shadow [NUM_CELLS];

  // A pending readback result holds off new input bytes.
  assign w_rb_hold = rb_valid;
`else
  assign w_rb_hold = 1'b0;
`endif

  // Frame parser FSM; every output is registered here.
  always_ff @(posedge QCK) begin
    if (QRT) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_bad_addr <= 1'b0;
      r_data     <= '0;
      r_chk      <= '0;
      r_cnt      <= '0;
      s_ready    <= 1'b0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
`ifdef PP3_CFG_READBACK_EN
      r_rb       <= 1'b0;
      rb_valid   <= 1'b0;
      rb_data    <= '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        r_shadow[i] <= '0;
      end
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      cfg_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          s_ready <= ~w_rb_hold;
          if (w_xfer) begin
            if (s_data == C_HDR_CFG) begin
              r_state <= S_ADDR;
              busy    <= 1'b1;
`ifdef PP3_CFG_READBACK_EN
              r_rb    <= 1'b0;
`endif
            end
`ifdef PP3_CFG_READBACK_EN
            else if (s_data == C_HDR_RB) begin
              r_state <= S_ADDR;
              busy    <= 1'b1;
              r_rb    <= 1'b1;
            end
`endif
            // Anything else is dropped while hunting for a header.
          end
        end

        S_ADDR: begin
          if (w_xfer) begin
            r_addr     <= s_data[ADDR_W-1:0];
            r_bad_addr <= w_bad_addr;
            r_chk      <= s_data;
            r_cnt      <= '0;
`ifdef PP3_CFG_READBACK_EN
            // Readback frames carry no payload.
            r_state    <= r_rb ? S_CHK : S_DATA;
`else
            r_state    <= S_DATA;
`endif
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            for (int k = 0; k < NBYTES; k++) begin
              if (r_cnt == CNT_W'(k)) begin
                r_data[8*k +: 8] <= s_data;
              end
            end
            r_chk <= r_chk ^ s_data;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_byte) begin
              r_state <= S_CHK;
            end
          end
        end

        S_CHK: begin
          if (w_xfer) begin
            if (r_bad_addr) begin
              // Address errors outrank checksum errors.
              err      <= 1'b1;
              err_code <= C_ERR_ADDR;
              r_state  <= S_IDLE;
              busy     <= 1'b0;
            end else if (s_data != r_chk) begin
              err      <= 1'b1;
              err_code <= C_ERR_CHK;
              r_state  <= S_IDLE;
              busy     <= 1'b0;
            end
`ifdef PP3_CFG_READBACK_EN
            else if (r_rb) begin
              rb_valid <= 1'b1;
              rb_data  <= r_shadow[r_addr];
              s_ready  <= 1'b0;
              r_state  <= S_IDLE;
              busy     <= 1'b0;
            end
`endif
            else begin
              // Latch outputs change only here, so rejected frames
              // never disturb the visible configuration word.
              cfg_we   <= 1'b1;
              done     <= 1'b1;
              cfg_addr <= r_addr;
              cfg_data <= r_data;
              s_ready  <= 1'b0;
              r_state  <= S_COMMIT;
`ifdef PP3_CFG_READBACK_EN
              r_shadow[r_addr] <= r_data;
`endif
            end
          end
        end

        S_COMMIT: begin
          s_ready <= ~w_rb_hold;
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase

`ifdef PP3_CFG_READBACK_EN
      // Readback result is consumed once the sink samples rb_ready high.
      if (rb_valid && rb_ready) begin
        rb_valid <= 1'b0;
        s_ready  <= 1'b1;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pp3_cfg_frame_loader.sv
`default_nettype none

module tb_pp3_cfg_frame_loader;

  localparam int NUM_CELLS = 4;
  localparam int CFG_BITS  = 16;
  localparam int ADDR_W    = 2;

  logic                QCK = 1'b0;
  logic                QRT = 1'b1;
  logic                s_valid = 1'b0;
  logic [7:0]          s_data = 8'h00;
  logic                s_ready;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [CFG_BITS-1:0] cfg_data;
  logic                busy;
  logic                done;
  logic                err;
  logic [1:0]          err_code;
`ifdef PP3_CFG_READBACK_EN
  logic                rb_valid;
  logic [CFG_BITS-1:0] rb_data;
  logic                rb_ready = 1'b0;
`endif

  pp3_cfg_frame_loader #(
    .NUM_CELLS(NUM_CELLS),
    .CFG_BITS (CFG_BITS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .QCK     (QCK),
    .QRT     (QRT),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_code(err_code)
`ifdef PP3_CFG_READBACK_EN
    ,
    .rb_valid(rb_valid),
    .rb_data (rb_data),
    .rb_ready(rb_ready)
`endif
  );

  always #5 QCK = ~QCK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                  is_err;
    logic [1:0]          code;
    logic [ADDR_W-1:0]   addr;
    logic [CFG_BITS-1:0] data;
  } exp_t;

  exp_t                sb[$];
  exp_t                mon_e;
  logic [ADDR_W-1:0]   m_addr = '0;
  logic [CFG_BITS-1:0] m_data = '0;
  logic                tb_rst_q = 1'b1;
  logic                exp_rdy;

  always @(posedge QCK) tb_rst_q <= QRT;

  // Scoreboard monitor: pops an expectation on every cfg_we/err pulse and
  // tracks the held cfg_addr/cfg_data and s_ready every cycle.
  always @(negedge QCK) begin
    if (!tb_rst_q) begin
      if (cfg_we === 1'b1 || err === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: cfg_we=%b err=%b code=%b, no event expected", cfg_we, err, err_code);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_err) begin
            if (err !== 1'b1 || cfg_we !== 1'b0 || err_code !== mon_e.code) begin
              errors++;
              $display("FAIL sb_err: got err=%b cfg_we=%b code=%b, want err=1 cfg_we=0 code=%b",
                       err, cfg_we, err_code, mon_e.code);
            end
          end else begin
            if (cfg_we !== 1'b1 || err !== 1'b0 || cfg_addr !== mon_e.addr || cfg_data !== mon_e.data) begin
              errors++;
              $display("FAIL sb_commit: got we=%b err=%b addr=%0d data=%h, want we=1 err=0 addr=%0d data=%h",
                       cfg_we, err, cfg_addr, cfg_data, mon_e.addr, mon_e.data);
            end else begin
              m_addr = mon_e.addr;
              m_data = mon_e.data;
            end
          end
        end
      end
      checks++;
      if (done !== cfg_we) begin
        errors++;
        $display("FAIL done_align: done=%b cfg_we=%b, want equal", done, cfg_we);
      end
      checks++;
      if (cfg_addr !== m_addr || cfg_data !== m_data) begin
        errors++;
        $display("FAIL cfg_held: addr=%0d data=%h, want addr=%0d data=%h", cfg_addr, cfg_data, m_addr, m_data);
      end
`ifdef PP3_CFG_READBACK_EN
      exp_rdy = !(cfg_we === 1'b1 || rb_valid === 1'b1);
`else
      exp_rdy = !(cfg_we === 1'b1);
`endif
      checks++;
      if (s_ready !== exp_rdy) begin
        errors++;
        $display("FAIL s_ready: got %b, want %b", s_ready, exp_rdy);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge QCK);
      s_valid = 1'b0;
    end
    @(negedge QCK);
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge QCK);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready=%b after 50 cycles, want 1", s_ready);
    end
    @(posedge QCK);
  endtask

  // Sends a full A5 frame, pushes the model's expected outcome and checks
  // that the result appears exactly one cycle after the checksum byte.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] ck, input int maxgap);
    exp_t e;
    logic [7:0] c;
    c = a ^ d0 ^ d1;
    e.addr = a[ADDR_W-1:0];
    e.data = {d1, d0};
    if (a >= 8'(NUM_CELLS)) begin
      e.is_err = 1'b1; e.code = 2'b10;
    end else if (ck != c) begin
      e.is_err = 1'b1; e.code = 2'b01;
    end else begin
      e.is_err = 1'b0; e.code = 2'b00;
    end
    sb.push_back(e);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(a,  $urandom_range(0, maxgap));
    send_byte(d0, $urandom_range(0, maxgap));
    send_byte(d1, $urandom_range(0, maxgap));
    send_byte(ck, $urandom_range(0, maxgap));
    @(negedge QCK);
    s_valid = 1'b0;
    checks++;
    if (cfg_we !== !e.is_err || err !== e.is_err) begin
      errors++;
      $display("FAIL latency: cfg_we=%b err=%b one cycle after checksum, want cfg_we=%b err=%b",
               cfg_we, err, !e.is_err, e.is_err);
    end
  endtask

  task automatic test_reset;
    QRT = 1'b1;
    repeat (2) @(posedge QCK);
    @(negedge QCK);
    checks++;
    if (s_ready !== 1'b0 || cfg_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
        cfg_addr !== '0 || cfg_data !== '0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b we=%b done=%b err=%b busy=%b addr=%0d data=%h code=%b, want all 0",
               s_ready, cfg_we, done, err, busy, cfg_addr, cfg_data, err_code);
    end
    QRT = 1'b0;
    @(negedge QCK);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: s_ready=%b after reset release, want 1", s_ready);
    end
  endtask

  task automatic test_basic;
    send_frame(8'h02, 8'h34, 8'h12, 8'h24, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL commit_busy: busy=%b in COMMIT, want 1", busy);
    end
    @(negedge QCK);
    checks++;
    if (cfg_we !== 1'b0 || cfg_addr !== 2'd2 || cfg_data !== 16'h1234 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: we=%b addr=%0d data=%h busy=%b err=%b, want 0 2 1234 0 0",
               cfg_we, cfg_addr, cfg_data, busy, err);
    end
  endtask

`ifdef PP3_CFG_READBACK_EN
  task automatic test_readback;
    rb_ready = 1'b0;
    send_byte(8'h5A, 0);
    send_byte(8'h02, 0);
    send_byte(8'h02, 0);
    @(negedge QCK);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rb_valid !== 1'b1 || rb_data !== 16'h1234 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL rb_hold: rb_valid=%b rb_data=%h s_ready=%b, want 1 1234 0", rb_valid, rb_data, s_ready);
      end
      if (i < 2) @(negedge QCK);
    end
    rb_ready = 1'b1;
    @(negedge QCK);
    rb_ready = 1'b0;
    checks++;
    if (rb_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rb_release: rb_valid=%b s_ready=%b, want 0 1", rb_valid, s_ready);
    end
  endtask
`endif

  task automatic test_bad_checksum;
    send_frame(8'h01, 8'hFF, 8'h00, 8'h00, 0);
    checks++;
    if (err_code !== 2'b01 || cfg_data !== 16'h1234) begin
      errors++;
      $display("FAIL bad_chk: code=%b data=%h, want 01 1234", err_code, cfg_data);
    end
    send_frame(8'h01, 8'hEF, 8'hBE, 8'h50, 0);
  endtask

  task automatic test_bad_addr;
    send_frame(8'h07, 8'h00, 8'h00, 8'h07, 0);
    @(negedge QCK);
    checks++;
    if (err_code !== 2'b10 || err !== 1'b0 || cfg_addr !== 2'd1 || cfg_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL bad_addr: code=%b err=%b addr=%0d data=%h, want 10 0 1 beef",
               err_code, err, cfg_addr, cfg_data);
    end
  endtask

  task automatic test_gaps;
    send_byte(8'h00, $urandom_range(0, 5));
    send_byte(8'hFF, $urandom_range(0, 5));
    send_byte(8'h5A, $urandom_range(0, 5));
    send_frame(8'h03, 8'hCD, 8'hAB, 8'h65, 5);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h00, 8'h01, 8'h02, 8'h03, 0);
    send_frame(8'h02, 8'h55, 8'hAA, 8'hFD, 0);
    send_frame(8'h03, 8'h10, 8'h20, 8'h00, 0);
    send_frame(8'h01, 8'h99, 8'h88, 8'h10, 0);
  endtask

  task automatic test_mid_reset;
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    @(negedge QCK);
    s_valid = 1'b0;
    QRT = 1'b1;
    @(posedge QCK);
    @(negedge QCK);
    QRT = 1'b0;
    m_addr = '0;
    m_data = '0;
    checks++;
    if (cfg_we !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || cfg_addr !== '0 || cfg_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: we=%b err=%b busy=%b addr=%0d data=%h, want all 0",
               cfg_we, err, busy, cfg_addr, cfg_data);
    end
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 0);
  endtask

  task automatic test_reset_at_commit;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge QCK);
    s_valid = 1'b1;
    s_data  = 8'h32;
    QRT     = 1'b1;
    @(posedge QCK);
    @(negedge QCK);
    QRT     = 1'b0;
    s_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    checks++;
    if (cfg_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cfg_data !== '0) begin
      errors++;
      $display("FAIL reset_commit: we=%b done=%b err=%b data=%h, want 0 0 0 0", cfg_we, done, err, cfg_data);
    end
    repeat (2) @(negedge QCK);
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef PP3_CFG_READBACK_EN
    test_readback();
`endif
    test_bad_checksum();
    test_bad_addr();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_reset_at_commit();
    repeat (3) @(negedge QCK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected events never seen, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
